// File: rtl/awb_gain_ctrl.sv
// Auto-white-balance gain controller: derives R/B gains from per-frame channel sums
// with a shared 40-bit restoring divider. Optional IIR smoothing when AWB_SMOOTH_EN is defined.
module awb_gain_ctrl #(
  parameter logic [9:0] GAIN_MAX     = 10'd1023,
  parameter logic [9:0] GAIN_MIN     = 10'd64,
  parameter int         SMOOTH_SHIFT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] r_sum_in,
  input  logic [31:0] g_sum_in,
  input  logic [31:0] b_sum_in,
  input  logic        frame_done_in,
  output logic [9:0]  r_gain_out,
  output logic [9:0]  g_gain_out,
  output logic [9:0]  b_gain_out,
  output logic        gain_valid_out,
  output logic        busy_out
);

  localparam logic [9:0] UNITY    = 10'd256;
  localparam logic [5:0] LAST_BIT = 6'd39;

  typedef enum logic [1:0] {IDLE, DIV_R, DIV_B, UPDATE} state_t;

  state_t      state_q, state_d;
  logic [31:0] r_sum_q, r_sum_d;
  logic [31:0] g_sum_q, g_sum_d;
  logic [31:0] b_sum_q, b_sum_d;
  logic [39:0] dvd_q, dvd_d;
  logic [31:0] rem_q, rem_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [9:0]  tgt_r_q, tgt_r_d;
  logic [9:0]  tgt_b_q, tgt_b_d;
  logic [9:0]  r_gain_q, r_gain_d;
  logic [9:0]  b_gain_q, b_gain_d;
  logic        vld_q, vld_d;

  logic [31:0] divisor;
  logic [32:0] rem_sh;
  logic        q_bit;
  logic [31:0] rem_step;
  logic [39:0] dvd_step;

  function automatic logic [9:0] clamp_quo(input logic [39:0] quo);
    logic [9:0] res;
    if (quo > {30'd0, GAIN_MAX})      res = GAIN_MAX;
    else if (quo < {30'd0, GAIN_MIN}) res = GAIN_MIN;
    else                              res = quo[9:0];
    return res;
  endfunction

  // A zero divisor or zero green sum leaves the channel at its current gain.
  function automatic logic [9:0] pick_tgt(input logic [31:0] div_sum,
                                          input logic [31:0] grn_sum,
                                          input logic [39:0] quo,
                                          input logic [9:0]  cur);
    logic [9:0] res;
    if (div_sum == 32'd0 || grn_sum == 32'd0) res = cur;
    else                                      res = clamp_quo(quo);
    return res;
  endfunction

`ifdef AWB_SMOOTH_EN
  function automatic logic [9:0] smooth_gain(input logic [9:0] old, input logic [9:0] tgt);
    logic signed [10:0] diff;
    logic signed [10:0] stp;
    logic signed [11:0] sum;
    logic [9:0]         res;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, old});
    stp  = diff >>> SMOOTH_SHIFT;
    sum  = $signed({2'b00, old}) + $signed({stp[10], stp});
    if (sum > $signed({2'b00, GAIN_MAX}))      res = GAIN_MAX;
    else if (sum < $signed({2'b00, GAIN_MIN})) res = GAIN_MIN;
    else                                       res = sum[9:0];
    return res;
  endfunction
`endif

  // One restoring-division step; the quotient shifts into the dividend register from the LSB.
  always_comb begin
    divisor  = (state_q == DIV_B) ? b_sum_q : r_sum_q;
    rem_sh   = {rem_q, dvd_q[39]};
    q_bit    = (rem_sh >= {1'b0, divisor});
    rem_step = q_bit ? 32'(rem_sh - {1'b0, divisor}) : rem_sh[31:0];
    dvd_step = {dvd_q[38:0], q_bit};
  end

  always_comb begin
    state_d  = state_q;
    r_sum_d  = r_sum_q;
    g_sum_d  = g_sum_q;
    b_sum_d  = b_sum_q;
    dvd_d    = dvd_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    tgt_r_d  = tgt_r_q;
    tgt_b_d  = tgt_b_q;
    r_gain_d = r_gain_q;
    b_gain_d = b_gain_q;
    vld_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_done_in) begin
          r_sum_d = r_sum_in;
          g_sum_d = g_sum_in;
          b_sum_d = b_sum_in;
          dvd_d   = {g_sum_in, 8'd0};
          rem_d   = 32'd0;
          cnt_d   = 6'd0;
          state_d = DIV_R;
        end
      end
      DIV_R: begin
        dvd_d = dvd_step;
        rem_d = rem_step;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST_BIT) begin
          tgt_r_d = pick_tgt(r_sum_q, g_sum_q, dvd_step, r_gain_q);
          dvd_d   = {g_sum_q, 8'd0};
          rem_d   = 32'd0;
          cnt_d   = 6'd0;
          state_d = DIV_B;
        end
      end
      DIV_B: begin
        dvd_d = dvd_step;
        rem_d = rem_step;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST_BIT) begin
          tgt_b_d = pick_tgt(b_sum_q, g_sum_q, dvd_step, b_gain_q);
          cnt_d   = 6'd0;
          state_d = UPDATE;
        end
      end
      UPDATE: begin
`ifdef AWB_SMOOTH_EN
        r_gain_d = smooth_gain(r_gain_q, tgt_r_q);
        b_gain_d = smooth_gain(b_gain_q, tgt_b_q);
`else
        r_gain_d = tgt_r_q;
        b_gain_d = tgt_b_q;
`endif
        vld_d    = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      r_sum_q  <= 32'd0;
      g_sum_q  <= 32'd0;
      b_sum_q  <= 32'd0;
      dvd_q    <= 40'd0;
      rem_q    <= 32'd0;
      cnt_q    <= 6'd0;
      tgt_r_q  <= UNITY;
      tgt_b_q  <= UNITY;
      r_gain_q <= UNITY;
      b_gain_q <= UNITY;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_sum_q  <= r_sum_d;
      g_sum_q  <= g_sum_d;
      b_sum_q  <= b_sum_d;
      dvd_q    <= dvd_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      tgt_r_q  <= tgt_r_d;
      tgt_b_q  <= tgt_b_d;
      r_gain_q <= r_gain_d;
      b_gain_q <= b_gain_d;
      vld_q    <= vld_d;
    end
  end

  assign r_gain_out     = r_gain_q;
  assign g_gain_out     = UNITY;
  assign b_gain_out     = b_gain_q;
  assign gain_valid_out = vld_q;
  assign busy_out       = (state_q != IDLE);

endmodule

// File: tb/tb_awb_gain_ctrl.sv
// Directed bench for awb_gain_ctrl; expected gains follow the AWB_SMOOTH_EN setting.
module tb_awb_gain_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] r_sum_in, g_sum_in, b_sum_in;
  logic        frame_done_in;
  logic [9:0]  r_gain_out, g_gain_out, b_gain_out;
  logic        gain_valid_out, busy_out;

  int vectors = 0;
  int miscompares = 0;

  awb_gain_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .r_sum_in       (r_sum_in),
    .g_sum_in       (g_sum_in),
    .b_sum_in       (b_sum_in),
    .frame_done_in  (frame_done_in),
    .r_gain_out     (r_gain_out),
    .g_gain_out     (g_gain_out),
    .b_gain_out     (b_gain_out),
    .gain_valid_out (gain_valid_out),
    .busy_out       (busy_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL timeout vectors=%0d", vectors);
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pick the expected value for the current build.
  function automatic logic [9:0] sel(input logic [9:0] plain, input logic [9:0] smooth);
`ifdef AWB_SMOOTH_EN
    return smooth;
`else
    return plain;
`endif
  endfunction

  task automatic pulse_frame(input logic [31:0] r, input logic [31:0] g, input logic [31:0] b);
    @(negedge clk);
    r_sum_in = r; g_sum_in = g; b_sum_in = b;
    frame_done_in = 1'b1;
    @(posedge clk); #1;
    frame_done_in = 1'b0;
  endtask

  task automatic run_frame(input string tag, input logic [31:0] r, input logic [31:0] g,
                           input logic [31:0] b, input logic [9:0] er, input logic [9:0] eb);
    int lat;
    pulse_frame(r, g, b);
    check({tag, "_busy"}, busy_out, 1);
    lat = 0;
    while (!gain_valid_out && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, 81);
    check({tag, "_r_gain"}, r_gain_out, er);
    check({tag, "_g_gain"}, g_gain_out, 256);
    check({tag, "_b_gain"}, b_gain_out, eb);
    @(posedge clk); #1;
    check({tag, "_valid_drop"}, gain_valid_out, 0);
    check({tag, "_idle"}, busy_out, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int pulses;
    int lat;
    rst_n = 1'b0;
    frame_done_in = 1'b0;
    r_sum_in = '0; g_sum_in = '0; b_sum_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_r_gain", r_gain_out, 256);
    check("rst_g_gain", g_gain_out, 256);
    check("rst_b_gain", b_gain_out, 256);
    check("rst_valid", gain_valid_out, 0);
    check("rst_busy", busy_out, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_frame("equal", 1000, 1000, 1000, 256, 256);
    run_frame("ratio1", 500, 1000, 2000, sel(512, 320), sel(128, 224));
    run_frame("ratio2", 500, 1000, 2000, sel(512, 368), sel(128, 200));
    run_frame("clamp", 100, 1000, 8000, sel(1023, 531), sel(64, 166));

    repeat (20) @(posedge clk);
    #1;
    check("hold_r", r_gain_out, sel(1023, 531));
    check("hold_b", b_gain_out, sel(64, 166));
    check("hold_valid", gain_valid_out, 0);

    // Zero red sum, plus a second frame_done 10 cycles in that must be dropped.
    apply_reset();
    pulse_frame(0, 1000, 2000);
    pulses = 0;
    lat = 0;
    for (int i = 1; i <= 150; i++) begin
      if (i == 10) begin
        r_sum_in = 100; g_sum_in = 1000; b_sum_in = 8000;
        frame_done_in = 1'b1;
      end
      @(posedge clk); #1;
      frame_done_in = 1'b0;
      if (gain_valid_out) begin
        pulses++;
        if (lat == 0) lat = i;
      end
    end
    check("rzero_pulses", pulses, 1);
    check("rzero_latency", lat, 81);
    check("rzero_r_gain", r_gain_out, 256);
    check("rzero_b_gain", b_gain_out, sel(128, 224));

    run_frame("gzero", 500, 0, 2000, 256, sel(128, 224));
    run_frame("pre_abort", 500, 1000, 2000, sel(512, 320), sel(128, 200));

    // Reset asserted mid-way through the red division.
    pulse_frame(500, 1000, 2000);
    repeat (29) begin
      @(posedge clk); #1;
    end
    check("abort_busy_before", busy_out, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy_out, 0);
    check("abort_r_gain", r_gain_out, 256);
    check("abort_b_gain", b_gain_out, 256);
    check("abort_valid", gain_valid_out, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (gain_valid_out) pulses++;
    end
    check("abort_no_pulse", pulses, 0);
    check("abort_idle", busy_out, 0);

    run_frame("fresh", 500, 1000, 2000, sel(512, 320), sel(128, 224));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/awb_gain_ctrl.md
AWB_GAIN_CTRL -- requirements
Module: awb_gain_ctrl

Interface
REQ-001 Parameter GAIN_MAX, default 10'd1023, upper clamp for any gain (Q2.8, 256 = 1.0).
REQ-002 Parameter GAIN_MIN, default 10'd64, lower clamp for any gain.
REQ-003 Parameter SMOOTH_SHIFT, default 2, IIR shift used when smoothing is compiled in.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 r_sum_in / g_sum_in / b_sum_in  input  32 each  per-frame channel sums from the upstream statistics stage.
REQ-007 frame_done_in  input  1  one-cycle pulse; the sums are valid in the same cycle.
REQ-008 r_gain_out / g_gain_out / b_gain_out  output  10 each  Q2.8 white-balance gains to the ISP gain stage.
REQ-009 gain_valid_out  output  1  one-cycle pulse when new gains are presented.
REQ-010 busy_out  output  1  high while a computation is in progress.

Function
REQ-011 FSM states: IDLE, DIV_R, DIV_B, UPDATE.
- IDLE -> DIV_R on frame_done_in.
- DIV_R -> DIV_B after 40 cycles.
- DIV_B -> UPDATE after 40 cycles.
- UPDATE -> IDLE after 1 cycle.
REQ-012 In IDLE, on frame_done_in the block shall latch all three sums into internal registers on the same edge.
REQ-013 DIV_R shall compute tgt_r = floor((g_sum << 8) / r_sum) with a 40-bit restoring divider, 1 quotient bit per cycle, 40 cycles.
REQ-014 DIV_B shall compute tgt_b = floor((g_sum << 8) / b_sum) with the same divider, reused.
REQ-015 Each 40-bit quotient shall be clamped to [GAIN_MIN, GAIN_MAX] before use.
REQ-016 If the divisor sum is 0, that channel's target shall equal its current gain; this bypasses the divider and clamp, and the cycle count is unchanged.
REQ-017 If g_sum is 0, both targets shall equal their current gains.
REQ-018 g_gain_out shall be constant 10'd256.
REQ-019 Gains shall update on the edge leaving UPDATE, 81 edges after the edge that sampled frame_done_in; gain_valid_out shall be high for exactly the following cycle.
REQ-020 busy_out shall be high in every state except IDLE.
REQ-021 frame_done_in arriving in any state other than IDLE shall be ignored, with no queuing and no effect on the current computation.
REQ-022 Outputs shall hold their values between updates.

Reset
REQ-023 Asserting rst_n at any time, including mid-division, shall immediately force:
- state = IDLE
- r_gain_out = g_gain_out = b_gain_out = 10'd256
- gain_valid_out = 0, busy_out = 0
- divider and latched sums = 0
REQ-024 After rst_n deasserts, the first frame_done_in shall start a fresh computation.

Configuration
REQ-025 Macro AWB_SMOOTH_EN, defined:
- UPDATE applies gain_new = gain_old + (signed 11-bit (tgt - gain_old) >>> SMOOTH_SHIFT).
- The shift is arithmetic (floor).
- The result is clamped to [GAIN_MIN, GAIN_MAX].
REQ-026 Macro AWB_SMOOTH_EN, undefined: UPDATE loads gain_new = tgt directly, and no smoothing logic is synthesized.

Verification
REQ-027 r=g=b=1000, frame_done -> after 81 edges, gains 256/256/256 and gain_valid_out pulses once (both macro settings).
REQ-028 Without AWB_SMOOTH_EN, r=500, g=1000, b=2000 -> r_gain 512, b_gain 128.
REQ-029 Without macro, r=100, g=1000, b=8000 -> r_gain 1023 (saturated from 2560), b_gain 64 (clamped from 32).
REQ-030 With AWB_SMOOTH_EN and SMOOTH_SHIFT=2, from reset, r=500, g=1000, b=2000 -> r_gain 320, b_gain 224; a repeated frame gives r_gain 368, b_gain 200.
REQ-031 r_sum=0, b=2000, g=1000 -> r_gain unchanged (256) and b_gain updated; a second frame_done 10 cycles after the first is ignored, with exactly one gain_valid_out pulse.
REQ-032 rst_n low at cycle 30 of DIV_R -> busy_out 0 and gains 256 immediately; no gain_valid_out pulse follows.
